// File: rtl/stream_cache_pkg.sv
// Shared widths, types and sid wrap helper for the stream request generator.
// Pure declarations: no latency, no flow control.
package stream_cache_pkg;

  localparam int unsigned addr_width   = 64;
  localparam int unsigned nstrms       = 64;
  localparam int unsigned nstrms_width = $clog2(nstrms);
  localparam int unsigned len_width    = 16;
  localparam int unsigned max_out      = 4;
  localparam int unsigned cnt_width    = $clog2(max_out + 1);

  typedef logic [nstrms_width-1:0] sid_t;
  typedef logic [addr_width-1:0]   ea_t;
  typedef logic [len_width-1:0]    len_t;
  typedef logic [cnt_width-1:0]    cnt_t;

  typedef struct packed {
    logic vld;
    sid_t sid;
    ea_t  ea;
  } req_t;

  // Stream id reached by stepping 'off' places past 'base', wrapping at nstrms.
  function automatic sid_t wrap_sid(sid_t base, int unsigned off);
    return sid_t'((32'(base) + off) % nstrms);
  endfunction

endpackage

// File: rtl/stream_rr_arb.sv
// Round-robin grant over the eligible-stream vector, starting after last_grant.
// Purely combinational (zero latency); no backpressure of its own.
module stream_rr_arb
  import stream_cache_pkg::*;
(
  input  logic [nstrms-1:0] req,
  input  sid_t              last_grant,
  output logic              grant_v,
  output sid_t              grant_sid
);

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    grant_v   = 1'b0;
    grant_sid = '0;
    for (int unsigned i = nstrms; i >= 1; i--) begin
      if (req[wrap_sid(last_grant, i)]) begin
        grant_v   = 1'b1;
        grant_sid = wrap_sid(last_grant, i);
      end
    end
  end

endmodule

// File: rtl/stream_req_gen.sv
// Per-stream line fetch generator with credit-limited outstanding requests and RR arbitration.
// Config to o_req_v is 2 cycles; the single output register holds while i_req_r is low.
module stream_req_gen
  import stream_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cfg_v,
  input  sid_t              i_cfg_sid,
  input  ea_t               i_cfg_ea,
  input  len_t              i_cfg_len,
  output logic              o_req_v,
  input  logic              i_req_r,
  output sid_t              o_req_sid,
  output ea_t               o_req_ea,
  input  logic              i_cred_v,
  input  sid_t              i_cred_sid,
  output logic [nstrms-1:0] o_busy,
  output logic              o_err
);

  logic [nstrms-1:0] elig;
  logic [nstrms-1:0] cred_err;
  ea_t               ea_tab [nstrms];

  logic grant_v;
  sid_t grant_sid;
  logic load;

  req_t req_q, req_d;
  logic err_q, err_d;
  sid_t last_grant_q, last_grant_d;

  assign load = grant_v && (!req_q.vld || i_req_r);

  stream_rr_arb u_arb (
    .req        (elig),
    .last_grant (last_grant_q),
    .grant_v    (grant_v),
    .grant_sid  (grant_sid)
  );

  for (genvar s = 0; s < nstrms; s++) begin : g_strm
    localparam sid_t this_sid = sid_t'(s);

    ea_t  next_ea_q, next_ea_d;
    len_t remain_q, remain_d;
    cnt_t outst_q, outst_d;
    logic cfg_hit, iss_hit, crd_hit;

    assign cfg_hit = i_cfg_v && (i_cfg_sid == this_sid);
    assign iss_hit = load && (grant_sid == this_sid);
    assign crd_hit = i_cred_v && (i_cred_sid == this_sid);

    assign elig[s]     = (remain_q != '0) && (outst_q < cnt_t'(max_out));
    assign o_busy[s]   = (remain_q != '0) || (outst_q != '0);
    assign cred_err[s] = crd_hit && !iss_hit && (outst_q == '0);
    assign ea_tab[s]   = next_ea_q;

    // A same-cycle issue still counts as outstanding even when config wins the
    // address/length update: that request really does leave the block.
    always_comb begin
      next_ea_d = next_ea_q;
      remain_d  = remain_q;
      outst_d   = outst_q;
      if (cfg_hit) begin
        next_ea_d = i_cfg_ea;
        remain_d  = i_cfg_len;
      end else if (iss_hit) begin
        next_ea_d = next_ea_q + ea_t'(1);
        remain_d  = remain_q - len_t'(1);
      end
      if (iss_hit && !crd_hit) begin
        outst_d = outst_q + cnt_t'(1);
      end else if (crd_hit && !iss_hit && (outst_q != '0)) begin
        outst_d = outst_q - cnt_t'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        next_ea_q <= '0;
        remain_q  <= '0;
        outst_q   <= '0;
      end else begin
        next_ea_q <= next_ea_d;
        remain_q  <= remain_d;
        outst_q   <= outst_d;
      end
    end
  end

  // The EA is captured at grant time, so a later reconfig cannot alter it.
  always_comb begin
    req_d        = req_q;
    last_grant_d = last_grant_q;
    err_d        = err_q || (|cred_err);
    if (load) begin
      req_d.vld    = 1'b1;
      req_d.sid    = grant_sid;
      req_d.ea     = ea_tab[grant_sid];
      last_grant_d = grant_sid;
    end else if (i_req_r) begin
      req_d.vld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q        <= '0;
      err_q        <= 1'b0;
      last_grant_q <= sid_t'(nstrms - 1);
    end else begin
      req_q        <= req_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_req_v   = req_q.vld;
  assign o_req_sid = req_q.sid;
  assign o_req_ea  = req_q.ea;
  assign o_err     = err_q;

endmodule

// File: doc/stream_req_gen.md
STREAM_REQ_GEN -- requirements
Module: stream_req_gen

Interface
REQ-001 Parameter addr_width, 64, effective-address width; EA is a cache-line index.
REQ-002 Parameter nstrms, 64, number of streams; nstrms_width = $clog2(nstrms).
REQ-003 Parameter len_width, 16, width of the per-stream line count.
REQ-004 Parameter max_out, 4, maximum outstanding requests per stream; cnt_width = $clog2(max_out+1).
REQ-005 clk  in  1  the single clock; all state on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 i_cfg_v  in  1  stream configuration strobe; always accepted, no ready.
REQ-008 i_cfg_sid  in  nstrms_width  stream being configured.
REQ-009 i_cfg_ea  in  addr_width  first line EA of the stream.
REQ-010 i_cfg_len  in  len_width  number of lines to fetch; 0 disables the stream.
REQ-011 o_req_v / i_req_r  out / in  1 / 1  request valid/ready toward the tag interface.
REQ-012 o_req_sid / o_req_ea  out / out  nstrms_width / addr_width  request stream id and line EA.
REQ-013 i_cred_v / i_cred_sid  in / in  1 / nstrms_width  one credit returned when a response for that sid is consumed.
REQ-014 o_busy  out  nstrms  bit s = stream s has remaining lines or outstanding requests.
REQ-015 o_err  out  1  sticky flag: credit returned to a stream with zero outstanding requests.

Function
REQ-016 Per-stream registered state SHALL be next_ea, remain (len_width), outst (cnt_width).
REQ-017 Stream s SHALL be eligible iff remain[s] != 0 and outst[s] < max_out.
REQ-018 A round-robin arbiter SHALL grant the first eligible stream searching from last_grant+1 upward, wrapping at nstrms-1 to 0.
REQ-019 Request output SHALL be a single register, loaded on a grant when o_req_v=0 or (o_req_v & i_req_r).
REQ-020 o_req_v, o_req_sid and o_req_ea SHALL hold stable while o_req_v=1 and i_req_r=0.
REQ-021 On load, the granted stream SHALL update next_ea += 1 (mod 2^addr_width), remain -= 1, outst += 1, and last_grant := sid.
REQ-022 Latency: config in cycle N makes the stream eligible in N+1 and gives o_req_v=1 in N+2 when the output register is free.
REQ-023 Sustained throughput SHALL be one request per cycle while i_req_r=1 and any stream is eligible.
REQ-024 i_cred_v SHALL decrement outst[i_cred_sid]; a credit and an issue to the same sid in one cycle SHALL leave outst unchanged.
REQ-025 A credit with outst=0 and no same-cycle issue SHALL leave outst at 0 and set o_err.
REQ-026 Config SHALL overwrite next_ea and remain, SHALL leave outst unchanged, and SHALL take priority over a same-cycle issue update to that stream.
REQ-027 A request already in the output register when its stream is reconfigured SHALL still be presented with its old EA.
REQ-028 o_busy[s] SHALL be (remain[s] != 0) | (outst[s] != 0), taken from registered state.

Reset
REQ-029 Reset assertion SHALL immediately clear, regardless of clk: o_req_v, o_req_sid, o_req_ea, o_err, all next_ea/remain/outst, o_busy, and last_grant (last_grant := nstrms-1, so sid 0 wins first).
REQ-030 Reset mid-transfer SHALL drop any pending request and all credit state, with no recovery.

Structure
REQ-031 addr_width, nstrms, nstrms_width, len_width, max_out and cnt_width SHALL live in the shared package stream_cache_pkg.
REQ-032 Round-robin grant logic SHALL be the sub-module stream_rr_arb (inputs req vector and last_grant; outputs grant_v and grant_sid).

Verification
REQ-033 Config sid 1, ea 0x2, len 3, i_req_r=1, credits returned immediately -> ea 0x2, 0x3, 0x4 on consecutive cycles starting N+2; o_busy[1] falls after the last credit.
REQ-034 Config sid 1, len 8, no credits -> exactly 4 requests (ea 0..3), then o_req_v=0; one credit -> exactly one more request, ea 4.
REQ-035 Config sids 0, 5 and 63, len 2 each -> grant order 0, 5, 63, 0, 5, 63.
REQ-036 i_req_r=0 for 5 cycles with o_req_v=1 -> sid and ea stay constant; release -> same request accepted once, no duplication.
REQ-037 Credit to sid 7 (idle) -> o_err=1 and stays 1; outst[7] stays 0.
REQ-038 Reset pulsed low mid-stream at a non-edge time -> o_req_v=0 immediately; after release, o_busy=0 and no requests are issued until a new config.
